// File: rtl/img2col_pkg.sv
// Shared state encoding, g-buffer geometry and round helpers for the img2col round scheduler.
package img2col_pkg;

  localparam int unsigned K           = 5;
  localparam int unsigned G_DEPTH     = K * K;
  localparam int unsigned G_LAST_ADDR = G_DEPTH - 1;
  localparam int unsigned G_COL_BASE  = G_DEPTH - K;
  localparam int unsigned ROUND_W     = 6;
  localparam int unsigned ROUND_MAX   = (1 << ROUND_W) - 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_KICK    = 3'd1,
    S_LOAD    = 3'd2,
    S_PU_WAIT = 3'd3,
    S_EMIT    = 3'd4,
    S_DONE    = 3'd5
  } sched_state_e;

  // The PU treats every round past ROUND_MAX like ROUND_MAX, so the index saturates there.
  function automatic logic [ROUND_W-1:0] round_sat_inc(input logic [ROUND_W-1:0] r);
    return (r == ROUND_W'(ROUND_MAX)) ? r : r + ROUND_W'(1);
  endfunction

endpackage

// File: rtl/img2col_win_pos.sv
// Window position tracker: output column/row, PU round index and last-window detect.
module img2col_win_pos
  import img2col_pkg::*;
#(
  parameter int unsigned DIM_W = 8
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               clr_i,
  input  logic               adv_i,
  input  logic [DIM_W-1:0]   col_max_i,
  input  logic [DIM_W-1:0]   row_max_i,
  output logic [DIM_W-1:0]   col_o,
  output logic [DIM_W-1:0]   row_o,
  output logic [ROUND_W-1:0] round_o,
  output logic               last_c_o
);

  logic [DIM_W-1:0]   col_q, col_d;
  logic [DIM_W-1:0]   row_q, row_d;
  logic [ROUND_W-1:0] round_q, round_d;

  // Row wrap restarts the round: the PU must reload a full window at each row start.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    round_d = round_q;
    if (clr_i) begin
      col_d   = '0;
      row_d   = '0;
      round_d = '0;
    end else if (adv_i) begin
      if (col_q == col_max_i) begin
        col_d   = '0;
        row_d   = row_q + DIM_W'(1);
        round_d = '0;
      end else begin
        col_d   = col_q + DIM_W'(1);
        round_d = round_sat_inc(round_q);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      col_q   <= '0;
      row_q   <= '0;
      round_q <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      round_q <= round_d;
    end
  end

  assign col_o    = col_q;
  assign row_o    = row_q;
  assign round_o  = round_q;
  assign last_c_o = (col_q == col_max_i) && (row_q == row_max_i);

endmodule

// File: rtl/img2col_round_sched.sv
// Frame sequencer for the img2col PU: loads g-buffer columns, kicks the PU, emits windows.
// Optional stall cycle counter enabled by defining IMG2COL_STALL_CNT_EN.
module img2col_round_sched
  import img2col_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DIM_W  = 8,
  parameter int unsigned PU_LAT = 4
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  input  logic [DIM_W-1:0]   cfg_img_w,
  input  logic [DIM_W-1:0]   cfg_img_h,
  input  logic               pix_valid,
  input  logic [DATA_W-1:0]  pix_data,
  output logic               pix_ready,
  output logic               g_wr_en,
  output logic [ADDR_W-1:0]  g_adrs,
  output logic [DATA_W-1:0]  g_data,
  output logic               pu_start,
  output logic [ROUND_W-1:0] pu_round,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [DIM_W-1:0]   win_col,
  output logic [DIM_W-1:0]   win_row,
  output logic               busy,
  output logic               frame_done,
`ifdef IMG2COL_STALL_CNT_EN
  output logic [31:0]        stall_cnt,
`endif
  output logic               cfg_err
);

  localparam int unsigned WAIT_W = (PU_LAT > 1) ? $clog2(PU_LAT) : 1;

  sched_state_e      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [DIM_W-1:0]  col_max_q, col_max_d;
  logic [DIM_W-1:0]  row_max_q, row_max_d;
  logic              cfg_err_d;
  logic              g_wr_en_d;
  logic [ADDR_W-1:0] g_adrs_d;
  logic [DATA_W-1:0] g_data_d;
  logic              cfg_ok_c, accept_start_c, win_hs_c, last_win_c;

  assign cfg_ok_c       = (cfg_img_w >= DIM_W'(K)) && (cfg_img_h >= DIM_W'(K));
  assign accept_start_c = (state_q == S_IDLE) && start && cfg_ok_c;
  assign win_hs_c       = (state_q == S_EMIT) && win_ready;

  img2col_win_pos #(.DIM_W(DIM_W)) u_win_pos (
    .clk       (clk),
    .nrst      (nrst),
    .clr_i     (accept_start_c),
    .adv_i     (win_hs_c),
    .col_max_i (col_max_q),
    .row_max_i (row_max_q),
    .col_o     (win_col),
    .row_o     (win_row),
    .round_o   (pu_round),
    .last_c_o  (last_win_c)
  );

  // Next-state and g-write mux; round 0 fills the whole buffer, later rounds only the new column.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wait_d    = wait_q;
    col_max_d = col_max_q;
    row_max_d = row_max_q;
    cfg_err_d = cfg_err;
    g_wr_en_d = 1'b0;
    g_adrs_d  = g_adrs;
    g_data_d  = g_data;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok_c) begin
            state_d   = S_KICK;
            cfg_err_d = 1'b0;
            col_max_d = cfg_img_w - DIM_W'(K);
            row_max_d = cfg_img_h - DIM_W'(K);
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_KICK: begin
        ptr_d   = (pu_round == '0) ? '0 : ADDR_W'(G_COL_BASE);
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (pix_valid) begin
          g_wr_en_d = 1'b1;
          g_adrs_d  = ptr_q;
          g_data_d  = pix_data;
          if (ptr_q == ADDR_W'(G_LAST_ADDR)) begin
            wait_d  = '0;
            state_d = S_PU_WAIT;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      S_PU_WAIT: begin
        if (wait_q == WAIT_W'(PU_LAT - 1)) begin
          state_d = S_EMIT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_EMIT: begin
        if (win_ready) begin
          state_d = last_win_c ? S_DONE : S_KICK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status strobes are registered from the next state so they line up with the state they report.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      wait_q     <= '0;
      col_max_q  <= '0;
      row_max_q  <= '0;
      cfg_err    <= 1'b0;
      g_wr_en    <= 1'b0;
      g_adrs     <= '0;
      g_data     <= '0;
      pix_ready  <= 1'b0;
      pu_start   <= 1'b0;
      win_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wait_q     <= wait_d;
      col_max_q  <= col_max_d;
      row_max_q  <= row_max_d;
      cfg_err    <= cfg_err_d;
      g_wr_en    <= g_wr_en_d;
      g_adrs     <= g_adrs_d;
      g_data     <= g_data_d;
      pix_ready  <= (state_d == S_LOAD);
      pu_start   <= (state_d == S_KICK);
      win_valid  <= (state_d == S_EMIT);
      busy       <= (state_d != S_IDLE);
      frame_done <= (state_d == S_DONE);
    end
  end

`ifdef IMG2COL_STALL_CNT_EN
  logic [31:0] stall_q;

  // Cycles lost to a starved source or a back-pressuring PE array.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_q <= '0;
    end else if (accept_start_c) begin
      stall_q <= '0;
    end else if (((state_q == S_LOAD) && !pix_valid) || ((state_q == S_EMIT) && !win_ready)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_img2col_round_sched.sv
// Scoreboard bench for img2col_round_sched: reference frame model, random pixel/ready pacing.
module tb_img2col_round_sched;
  import img2col_pkg::*;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DIM_W  = 8;
  localparam int unsigned PU_LAT = 4;
  localparam int FRAME_BUDGET    = 20000;

  logic               clk = 1'b0;
  logic               nrst = 1'b0;
  logic               start = 1'b0;
  logic [DIM_W-1:0]   cfg_img_w = '0;
  logic [DIM_W-1:0]   cfg_img_h = '0;
  logic               pix_valid = 1'b0;
  logic [DATA_W-1:0]  pix_data = '0;
  logic               pix_ready;
  logic               g_wr_en;
  logic [ADDR_W-1:0]  g_adrs;
  logic [DATA_W-1:0]  g_data;
  logic               pu_start;
  logic [ROUND_W-1:0] pu_round;
  logic               win_valid;
  logic               win_ready = 1'b1;
  logic [DIM_W-1:0]   win_col;
  logic [DIM_W-1:0]   win_row;
  logic               busy;
  logic               frame_done;
  logic               cfg_err;
`ifdef IMG2COL_STALL_CNT_EN
  logic [31:0]        stall_cnt;
`endif

  img2col_round_sched #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .PU_LAT(PU_LAT)
  ) dut (
    .clk(clk), .nrst(nrst), .start(start),
    .cfg_img_w(cfg_img_w), .cfg_img_h(cfg_img_h),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .g_wr_en(g_wr_en), .g_adrs(g_adrs), .g_data(g_data),
    .pu_start(pu_start), .pu_round(pu_round),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_col(win_col), .win_row(win_row),
    .busy(busy), .frame_done(frame_done),
`ifdef IMG2COL_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int valid_pct = 100;
  bit stall_en = 1'b0;
  int hold = 0;

  logic [DATA_W-1:0] pix_q[$];
  int exp_adr_q[$];
  int exp_dat_q[$];
  int exp_col_q[$];
  int exp_row_q[$];
  int exp_rnd_q[$];

  bit pend = 1'b0;
  int p_col, p_row, p_rnd;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: windows in raster order; the round equals the column index (saturated),
  // the first window of each row loads all 25 cells, the rest load the last column only.
  task automatic build_frame(input int w, input int h);
    int d;
    for (int r = 0; r <= h - int'(K); r++) begin
      for (int c = 0; c <= w - int'(K); c++) begin
        exp_col_q.push_back(c);
        exp_row_q.push_back(r);
        exp_rnd_q.push_back((c > int'(ROUND_MAX)) ? int'(ROUND_MAX) : c);
        for (int a = (c == 0) ? 0 : int'(K * K - K); a < int'(K * K); a++) begin
          d = int'($urandom_range(16'hFFFF));
          pix_q.push_back(DATA_W'(d));
          exp_adr_q.push_back(a);
          exp_dat_q.push_back(d);
        end
      end
    end
  endtask

  task automatic clear_model();
    pix_q.delete();
    exp_adr_q.delete(); exp_dat_q.delete();
    exp_col_q.delete(); exp_row_q.delete(); exp_rnd_q.delete();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_pix_ready"}, pix_ready, 0);
    chk({tag, "_g_wr_en"}, g_wr_en, 0);
    chk({tag, "_g_adrs"}, g_adrs, 0);
    chk({tag, "_g_data"}, g_data, 0);
    chk({tag, "_pu_start"}, pu_start, 0);
    chk({tag, "_pu_round"}, pu_round, 0);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_win_col"}, win_col, 0);
    chk({tag, "_win_row"}, win_row, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  // Pixel source with random gaps.
  initial begin
    forever begin
      @(negedge clk);
      if (pix_q.size() > 0 && int'($urandom_range(99)) < valid_pct) begin
        pix_valid = 1'b1;
        pix_data  = pix_q[0];
      end else begin
        pix_valid = 1'b0;
      end
      #1;
      if (pix_valid && pix_ready) void'(pix_q.pop_front());
    end
  end

  // Downstream: always ready, or holds each window for 10 cycles before accepting.
  initial begin
    forever begin
      @(negedge clk);
      if (!stall_en) begin
        win_ready = 1'b1;
      end else if (win_valid && hold >= 10) begin
        win_ready = 1'b1;
        hold = 0;
      end else begin
        win_ready = 1'b0;
        if (win_valid) hold++;
      end
    end
  end

  // Monitor: g writes, window handshakes, window stability while stalled, frame_done count.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!nrst) begin
        pend = 1'b0;
      end else begin
        if (g_wr_en) begin
          if (exp_adr_q.size() == 0) begin
            chk("g_write_unexpected", g_adrs, -1);
          end else begin
            chk("g_adrs", g_adrs, exp_adr_q.pop_front());
            chk("g_data", g_data, exp_dat_q.pop_front());
          end
        end
        if (win_valid) begin
          if (pend) begin
            chk("win_col_stable", win_col, p_col);
            chk("win_row_stable", win_row, p_row);
            chk("pu_round_stable", pu_round, p_rnd);
          end
          p_col = int'(win_col); p_row = int'(win_row); p_rnd = int'(pu_round);
          pend = !win_ready;
          if (win_ready) begin
            if (exp_col_q.size() == 0) begin
              chk("win_unexpected", win_col, -1);
            end else begin
              chk("win_col", win_col, exp_col_q.pop_front());
              chk("win_row", win_row, exp_row_q.pop_front());
              chk("pu_round", pu_round, exp_rnd_q.pop_front());
            end
          end
        end else begin
          pend = 1'b0;
        end
        if (frame_done) fd_cnt++;
      end
    end
  end

  task automatic run_frame(input int w, input int h, input bit chk_lat, input bit poke);
    int  c;
    int  fd0;
    bit  done;
    bit  seen_v;
    build_frame(w, h);
    fd0 = fd_cnt;
    start = 1'b1; cfg_img_w = DIM_W'(w); cfg_img_h = DIM_W'(h);
    @(negedge clk);
    start = 1'b0;
    c = 1; done = 1'b0; seen_v = 1'b0;
    while (!done && c < FRAME_BUDGET) begin
      @(negedge clk);
      c++;
      if (c == 2) begin
        chk("busy_after_start", busy, 1);
        chk("cfg_err_after_start", cfg_err, 0);
      end
      if (poke && c == 5) begin start = 1'b1; cfg_img_w = DIM_W'(4); end
      if (poke && c == 6) start = 1'b0;
      if (poke && c == 7) chk("cfg_err_start_while_busy", cfg_err, 0);
      if (chk_lat && !seen_v && win_valid) begin
        seen_v = 1'b1;
        chk("first_win_cycle", c, 1 + 1 + int'(K * K) + int'(PU_LAT));
      end
      if (frame_done) begin
        done = 1'b1;
        if (chk_lat) chk("frame_done_cycle", c, 2 + 1 + int'(K * K) + int'(PU_LAT));
      end
    end
    if (!done) chk("frame_timeout", c, -1);
    @(negedge clk);
    chk("busy_after_frame", busy, 0);
    chk("frame_done_count", fd_cnt, fd0 + 1);
    chk("pixels_left", pix_q.size(), 0);
    chk("writes_left", exp_adr_q.size(), 0);
    chk("windows_left", exp_col_q.size(), 0);
    if (!done) clear_model();
  endtask

  task automatic reject(input int w, input int h);
    start = 1'b1; cfg_img_w = DIM_W'(w); cfg_img_h = DIM_W'(h);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("cfg_err_rejected", cfg_err, 1);
    chk("busy_rejected", busy, 0);
    chk("pu_start_rejected", pu_start, 0);
  endtask

  initial begin
    int fd0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    nrst = 1'b1;
    @(negedge clk);
    chk_quiet("post_reset");

    valid_pct = 100; stall_en = 1'b0;
    run_frame(5, 5, 1'b1, 1'b0);
    run_frame(7, 5, 1'b0, 1'b1);
    run_frame(6, 6, 1'b0, 1'b0);
    run_frame(5, 7, 1'b0, 1'b0);

    valid_pct = 50; stall_en = 1'b1;
    run_frame(7, 6, 1'b0, 1'b0);

    valid_pct = 100; stall_en = 1'b0;
    reject(4, 5);
    reject(5, 3);
    run_frame(5, 5, 1'b1, 1'b0);

    // Reset in the middle of the LOAD phase.
    build_frame(5, 5);
    fd0 = fd_cnt;
    start = 1'b1; cfg_img_w = DIM_W'(5); cfg_img_h = DIM_W'(5);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pix_ready_in_load", pix_ready, 1);
    #3 nrst = 1'b0;
    #1 chk_quiet("mid_reset");
    clear_model();
    @(negedge clk);
    chk_quiet("mid_reset_edge");
    nrst = 1'b1;
    @(negedge clk);
    chk("no_frame_done_on_reset", fd_cnt, fd0);
    run_frame(5, 5, 1'b1, 1'b0);

    // Wide frame to reach round saturation.
    run_frame(70, 5, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      valid_pct = int'($urandom_range(30, 100));
      stall_en  = 1'($urandom_range(1));
      run_frame(int'($urandom_range(5, 10)), int'($urandom_range(5, 7)), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
